// File: rtl/cim_vector_sequencer.sv
// cim_vector_sequencer: walks a batch of activation vectors through the CIM
// bit-serial path. Each vector is fetched from the activation buffer, and the
// serializer is started. The per-plane column sums are then shift-accumulated
// into one weighted result per vector.
// Optional build macro CIM_SEQ_SIGNED_MSB_EN: the most significant plane is
// subtracted, so the activation is treated as two's complement and acc_out
// is a signed result. Without the macro every plane is added (unsigned).
module cim_vector_sequencer #(
  parameter int ADDR_W = 8,
  parameter int NVEC_W = 8,
  parameter int SUM_W  = 8,
  parameter int ACC_W  = SUM_W + 9
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [NVEC_W-1:0] cfg_num_vec,
  input  logic              cfg_in_fp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              ser_data_valid,
  output logic              ser_in_fp,
  input  logic              ser_data_done,
  input  logic              mac_valid,
  input  logic [SUM_W-1:0]  mac_sum,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_STREAM,
    S_OUTPUT
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        addr;
  logic [NVEC_W-1:0]        num_vec;
  logic [NVEC_W-1:0]        num_vec_m1;
  logic [NVEC_W-1:0]        vec_cnt;
  logic                     in_fp;
  logic [3:0]               plane_cnt;
  logic [3:0]               nbits;
  logic                     done_seen;
  logic                     zero_done;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_hold;
  logic                     accept;
  logic                     plane_ok;
  logic                     stream_exit;
  logic                     last_vec;
  logic                     err_evt;

  // Zero-extend a plane's column sum and weight it by its bit position.
  function automatic logic signed [ACC_W-1:0] plane_term(input logic [SUM_W-1:0] sum,
                                                         input logic [3:0]       sh);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(sum) << sh;
    return signed'(ext);
  endfunction

  assign nbits       = in_fp ? 4'd3 : 4'd8;
  assign num_vec_m1  = num_vec - 1'b1;
  assign last_vec    = (vec_cnt == num_vec_m1);
  assign accept      = (state == S_IDLE) && start && !abort;
  assign plane_ok    = mac_valid && (state == S_STREAM) && (plane_cnt < nbits);
  assign stream_exit = (done_seen || ser_data_done) && (plane_cnt == nbits);
  // Planes beyond NBITS or outside STREAM are dropped and flagged.
  assign err_evt     = (mac_valid && !plane_ok) ||
                       (ser_data_done && (state != S_STREAM));

  assign busy        = (state != S_IDLE);
  assign buf_rd_addr = addr;
  assign ser_in_fp   = in_fp;
  // The live accumulator is shown during OUTPUT; afterwards the last result holds.
  assign acc_out     = acc_valid ? acc : acc_hold;

  // Next-state and per-state strobes; abort overrides every non-idle transition.
  always_comb begin
    state_nxt      = state;
    buf_rd_en      = 1'b0;
    ser_data_valid = 1'b0;
    acc_valid      = 1'b0;
    done           = zero_done;
    case (state)
      S_IDLE: begin
        if (accept && (cfg_num_vec != '0)) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        buf_rd_en = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ser_data_valid = 1'b1;
        state_nxt      = S_STREAM;
      end
      S_STREAM: begin
        if (stream_exit) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        acc_valid = !abort;
        done      = zero_done | (!abort && last_vec);
        state_nxt = last_vec ? S_IDLE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // State register, latched batch configuration, counters and accumulator.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      addr      <= '0;
      num_vec   <= '0;
      vec_cnt   <= '0;
      in_fp     <= 1'b0;
      plane_cnt <= '0;
      done_seen <= 1'b0;
      zero_done <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      acc_hold  <= '0;
    end else begin
      state     <= state_nxt;
      zero_done <= accept && (cfg_num_vec == '0);
      err       <= (err && !accept) || err_evt;
      if (accept) begin
        num_vec <= cfg_num_vec;
        in_fp   <= cfg_in_fp;
        addr    <= cfg_base_addr;
        vec_cnt <= '0;
      end
      case (state)
        S_ISSUE: begin
          acc       <= '0;
          plane_cnt <= '0;
          done_seen <= 1'b0;
        end
        S_STREAM: begin
          if (plane_ok) begin
`ifdef CIM_SEQ_SIGNED_MSB_EN
            if (plane_cnt == (nbits - 4'd1)) acc <= acc - plane_term(mac_sum, plane_cnt);
            else                             acc <= acc + plane_term(mac_sum, plane_cnt);
`else
            acc <= acc + plane_term(mac_sum, plane_cnt);
`endif
            plane_cnt <= plane_cnt + 4'd1;
          end
          if (ser_data_done) done_seen <= 1'b1;
        end
        S_OUTPUT: begin
          if (!abort) begin
            acc_hold <= acc;
            vec_cnt  <= vec_cnt + 1'b1;
            if (!last_vec) addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_vector_sequencer.sv
// Directed testbench for cim_vector_sequencer with an expected-result queue.
module tb_cim_vector_sequencer;

  localparam int ADDR_W = 8;
  localparam int NVEC_W = 8;
  localparam int SUM_W  = 8;
  localparam int ACC_W  = SUM_W + 9;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [NVEC_W-1:0] cfg_num_vec;
  logic              cfg_in_fp;
  logic              busy;
  logic              done;
  logic              err;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              ser_data_valid;
  logic              ser_in_fp;
  logic              ser_data_done;
  logic              mac_valid;
  logic [SUM_W-1:0]  mac_sum;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ACC_W-1:0] exp_q[$];
  int sums[8];

  cim_vector_sequencer #(
    .ADDR_W(ADDR_W), .NVEC_W(NVEC_W), .SUM_W(SUM_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .RSTN(rstn), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_num_vec(cfg_num_vec), .cfg_in_fp(cfg_in_fp),
    .busy(busy), .done(done), .err(err),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .ser_data_valid(ser_data_valid), .ser_in_fp(ser_in_fp),
    .ser_data_done(ser_data_done), .mac_valid(mac_valid), .mac_sum(mac_sum),
    .acc_out(acc_out), .acc_valid(acc_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference weighting of bit-plane sums.
  function automatic logic [ACC_W-1:0] model(input int nb);
    int v;
    v = 0;
    for (int p = 0; p < nb; p++) begin
`ifdef CIM_SEQ_SIGNED_MSB_EN
      if (p == nb - 1) v = v - (sums[p] << p);
      else             v = v + (sums[p] << p);
`else
      v = v + (sums[p] << p);
`endif
    end
    return ACC_W'(v);
  endfunction

  task automatic start_batch(input logic [7:0] base, input logic [7:0] n, input logic fp);
    start = 1'b1; cfg_base_addr = base; cfg_num_vec = n; cfg_in_fp = fp;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vector(input string tag, input logic [7:0] exp_addr, input int nb,
                            input logic fp, input logic last, input logic extra);
    logic [ACC_W-1:0] e;
    for (int i = 0; i < 20 && buf_rd_en !== 1'b1; i++) tick();
    chk({tag, "_fetch"}, buf_rd_en, 1);
    chk({tag, "_addr"}, buf_rd_addr, exp_addr);
    tick();
    chk({tag, "_ser_valid"}, ser_data_valid, 1);
    chk({tag, "_ser_fp"}, ser_in_fp, fp);
    exp_q.push_back(model(nb));
    tick();
    for (int p = 0; p < nb; p++) begin
      mac_valid = 1'b1; mac_sum = SUM_W'(sums[p]);
      tick();
    end
    if (extra) begin
      mac_sum = 8'hFF;
      tick();
      chk({tag, "_err_extra"}, err, 1);
    end
    mac_valid = 1'b0;
    ser_data_done = 1'b1;
    tick();
    ser_data_done = 1'b0;
    for (int i = 0; i < 20 && acc_valid !== 1'b1; i++) tick();
    chk({tag, "_acc_valid"}, acc_valid, 1);
    if (exp_q.size() == 0) chk({tag, "_queue"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_acc"}, acc_out, e);
    end
    chk({tag, "_done"}, done, last);
    tick();
    if (last) begin
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_after"}, done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_base_addr = '0; cfg_num_vec = '0;
    cfg_in_fp = 1'b0; ser_data_done = 1'b0; mac_valid = 1'b0; mac_sum = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {buf_rd_en, ser_data_valid, acc_valid, ser_in_fp}, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_addr", buf_rd_addr, 0);
    rstn = 1'b1;
    tick();

    // Normal batch: two 8-plane vectors of all-ones sums.
    for (int p = 0; p < 8; p++) sums[p] = 1;
    start_batch(8'h10, 8'd2, 1'b0);
    chk("nb_busy", busy, 1);
    run_vector("nb0", 8'h10, 8, 1'b0, 1'b0, 1'b0);
    run_vector("nb1", 8'h11, 8, 1'b0, 1'b1, 1'b0);

    // Reduced-precision mode, 3 planes.
    sums[0] = 5; sums[1] = 3; sums[2] = 2;
    start_batch(8'h05, 8'd1, 1'b1);
    run_vector("fp", 8'h05, 3, 1'b1, 1'b1, 1'b0);
    chk("fp_err", err, 0);

    // Empty batch.
    start_batch(8'h40, 8'd0, 1'b0);
    chk("zero_done", done, 1);
    chk("zero_rd", buf_rd_en, 0);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_clr", done, 0);
    chk("zero_rd2", buf_rd_en, 0);

    // Address wrap with random sums.
    for (int p = 0; p < 8; p++) sums[p] = int'($urandom_range(0, 255));
    start_batch(8'hFF, 8'd2, 1'b0);
    run_vector("wrap0", 8'hFF, 8, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++) sums[p] = int'($urandom_range(0, 255));
    run_vector("wrap1", 8'h00, 8, 1'b0, 1'b1, 1'b0);

    // Abort during STREAM after four planes.
    start_batch(8'h20, 8'd3, 1'b0);
    for (int i = 0; i < 20 && buf_rd_en !== 1'b1; i++) tick();
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      mac_valid = 1'b1; mac_sum = 8'h11;
      tick();
    end
    mac_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_acc_valid", acc_valid, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_quiet", {acc_valid, done, buf_rd_en}, 0);
    for (int p = 0; p < 8; p++) sums[p] = int'($urandom_range(0, 255));
    start_batch(8'h30, 8'd1, 1'b0);
    run_vector("post_abort", 8'h30, 8, 1'b0, 1'b1, 1'b0);

    // Ninth plane is an error and is not accumulated.
    for (int p = 0; p < 8; p++) sums[p] = 1;
    start_batch(8'h50, 8'd1, 1'b0);
    run_vector("extra", 8'h50, 8, 1'b0, 1'b1, 1'b1);
    chk("extra_err_sticky", err, 1);
    start_batch(8'h00, 8'd0, 1'b0);
    chk("err_clr_on_start", err, 0);
    tick();
    mac_valid = 1'b1; mac_sum = 8'h01;
    tick();
    mac_valid = 1'b0;
    chk("err_idle_mac", err, 1);
    for (int p = 0; p < 8; p++) sums[p] = 8 * p + 3;
    start_batch(8'h60, 8'd1, 1'b0);
    chk("err_clr2", err, 0);
    run_vector("clean", 8'h60, 8, 1'b0, 1'b1, 1'b0);
    chk("clean_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
